// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation and FSM state encodings.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } muldiv_state_t;

   function automatic logic op_is_div(input muldiv_op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input muldiv_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage to multiply/divide unit bundle: issue, MTHI/MTLO writes, status and HI/LO.
interface muldiv_if #(parameter int WIDTH = 32);
   import muldiv_pkg::*;

   logic             start;
   muldiv_op_t       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, flush, hi_we, lo_we, wd,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, flush, hi_we, lo_we, wd,
      output busy, done, div_by_zero, hi, lo
   );

endinterface

// File: rtl/muldiv_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result sign fix-up.
module cond_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU with architectural HI/LO registers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; MTHI/MTLO writes accepted
//   ST_RUN  | one multiplier bit / quotient bit per cycle, cnt counts down
//   ST_FIX  | sign fix-up of magnitudes, HI/LO written, done next cycle
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic     clk,
   input  logic     reset_n,
   muldiv_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   muldiv_state_t    state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
   logic             is_div, neg_q, neg_r, dz;
   logic [WIDTH-1:0] hi_r, lo_r;
   logic             done_r, dbz_r;
   logic             busy, load, step, fix_we;

   logic             in_div, in_signed;
   logic [WIDTH-1:0] na_in, nb_in, na_out, nb_out;
   logic             na_neg, nb_neg;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic             div_ge;
   logic [WIDTH-1:0] res_hi, res_lo;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.flush) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy   = (state != ST_IDLE);
      load   = (state == ST_IDLE) && bus.start && !bus.flush;
      step   = (state == ST_RUN) && !bus.flush;
      fix_we = (state == ST_FIX) && !bus.flush;
   end

   assign in_div    = op_is_div(bus.op);
   assign in_signed = op_is_signed(bus.op);

   // The two W-bit negators take absolute values at issue and fix up remainder/quotient in FIX.
   always_comb begin
      if (state == ST_FIX) begin
         na_in  = acc_hi;
         na_neg = neg_r;
         nb_in  = acc_lo;
         nb_neg = neg_q;
      end else begin
         na_in  = bus.src_a;
         na_neg = in_signed & bus.src_a[WIDTH-1];
         nb_in  = bus.src_b;
         nb_neg = in_signed & bus.src_b[WIDTH-1];
      end
   end

   cond_negate #(.WIDTH(WIDTH)) u_neg_a (.a(na_in), .neg(na_neg), .y(na_out));
   cond_negate #(.WIDTH(WIDTH)) u_neg_b (.a(nb_in), .neg(nb_neg), .y(nb_out));
   cond_negate #(.WIDTH(2*WIDTH)) u_neg_p (.a({acc_hi, acc_lo}), .neg(neg_q), .y(prod_fix));

   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   // Partial remainder stays below the divisor, so a set top bit already guarantees a fit.
   assign div_ge    = div_shift[WIDTH] | ~div_diff[WIDTH];

   always_comb begin
      if (is_div) begin
         res_hi = na_out;
         res_lo = dz ? '1 : nb_out;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
      end else if (load) begin
         cnt    <= CNT_W'(WIDTH);
         acc_hi <= '0;
         acc_lo <= in_div ? na_out : nb_out;
         opnd   <= in_div ? nb_out : na_out;
         is_div <= in_div;
         neg_q  <= in_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
         neg_r  <= in_signed & bus.src_a[WIDTH-1];
         dz     <= in_div && (bus.src_b == '0);
      end else if (step) begin
         cnt <= cnt - CNT_W'(1);
         if (is_div) begin
            acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
         end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_r   <= '0;
         lo_r   <= '0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
      end else begin
         done_r <= fix_we;
         dbz_r  <= fix_we & dz;
         if (fix_we) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
         end else if (!busy) begin
            if (bus.hi_we) hi_r <= bus.wd;
            if (bus.lo_we) lo_r <= bus.wd;
         end
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers, executing MULT, MULTU, DIV and DIVU for the MIPS pipeline beside the single-cycle ALU. The execute stage issues one operation with a start pulse. The unit runs one bit per cycle, stalls the pipeline through `busy`, and pulses `done` when HI/LO hold the result. MTHI/MTLO write HI/LO directly; MFHI/MFLO read them combinationally.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be at least 4.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: issue operation; accepted only when `busy`=0.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `src_a` input WIDTH: multiplicand / dividend.
- `src_b` input WIDTH: multiplier / divisor.
- `flush` input 1: abort the operation in flight.
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wd` input WIDTH: MTHI/MTLO write data.
- `busy` output 1: an operation is in flight; the pipeline must stall MFHI/MFLO and new mult/div.
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `div_by_zero` output 1: valid with `done`; divisor was zero.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + `start` + no `flush`:
  - latch `|src_a|` and `|src_b|` (raw values for the U ops);
  - record result signs: product and quotient negative iff signs differ; remainder takes the dividend's sign;
  - load counter = WIDTH; go to RUN.
- RUN, multiply: shift-add into a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division with a WIDTH+1-bit subtractor, one quotient bit per cycle, MSB first.
- RUN: counter decrements each cycle; at 1 go to FIX.
- FIX:
  - conditionally two's-complement negate the results;
  - write HI/LO: multiply gives HI = upper half, LO = lower half; divide gives LO = quotient, HI = remainder;
  - set `done` for the next cycle; return to IDLE.
- Divide by zero: full latency regardless of signedness; LO = all ones, HI = `src_a` as sampled; `div_by_zero`=1 with `done`.
- Signed most-negative ÷ −1: LO = most-negative, HI = 0, no flag.
- `start` while `busy`=1: ignored.
- `flush`: any state returns to IDLE next edge; HI/LO unchanged; no `done`. `flush` with `start` in IDLE: the start is dropped.
- `hi_we`/`lo_we`:
  - honoured only when `busy`=0, ignored while busy;
  - if asserted on the same edge as an accepted start, the write lands now and the result overwrites it later;
  - the FIX write has priority over a same-edge MTHI/MTLO write.

## Timing
- Reset: state IDLE; `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0; accumulator and counter cleared.
- Start accepted at edge E:
  - `busy`=1 from E through edge E+WIDTH+1;
  - HI/LO update at edge E+WIDTH+1;
  - `done`=1 for exactly the cycle after E+WIDTH+1, with `busy`=0 in that cycle.
- Latency is WIDTH+1 edges (33 at WIDTH=32). A new start is accepted in the `done` cycle.
- `hi`/`lo` are direct register outputs with no bypass.
- Reset asserted mid-operation: immediate return to reset values; no `done`.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum for the four ops;
  - `muldiv_state_t` enum for IDLE/RUN/FIX;
  - op encoding constants shared with the controller decoder.
- Sub-module `cond_negate #(WIDTH)`: combinational `y = neg ? -a : a`. Used for operand absolute values and result fix-up (three instances).
- Counter width: `$clog2(WIDTH+1)`.

## Test plan
- MULT −3 × 5 (0xFFFFFFFD, 0x00000005): `done` 33 edges after start; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. MULT with the same operands: HI=0, LO=1.
- DIV −7 ÷ 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 ÷ 7: LO=14, HI=2. DIV 0x80000000 ÷ 0xFFFFFFFF: LO=0x80000000, HI=0.
- DIVU 5 ÷ 0: `done` with `div_by_zero`=1; LO=0xFFFFFFFF, HI=5.
- Multi-step sequence:
  - MTHI 0x1234 in IDLE, then read HI: 0x1234;
  - start a MULT, then `start` again at cycle 10: ignored, one `done` only;
  - `flush` at cycle 20: no `done`, HI/LO unchanged, `busy`=0 next cycle.
- `reset_n` low mid-DIV at cycle 15: `busy`, `done`, HI, LO all 0 immediately. After release, a fresh MULTU 6 × 7 gives LO=42, HI=0.
